seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 142 ++++++++++++++
 tb/tb_seg_scan_decoder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Recovers the displayed digits from a multiplexed 7-segment drive (active-low
// anodes/segments), assembling one frame per full anode sweep.
module seg_scan_decoder #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg,
   input  logic [3:0]  an,
   input  logic        dp,
   output logic [15:0] digits,
   output logic [3:0]  dp_mask,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        an_err
);

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   state_t           r_state, w_state_nxt;
   logic [11:0]      r_prev;
   logic [11:0]      w_cur;
   logic [3:0]       r_cnt, w_cnt_nxt;
   logic             w_chg, w_onehot, w_an_bad, w_cap, w_done;
   logic [3:0]       w_code;
   logic             w_code_err;
   logic [3:0][3:0]  r_buf, w_buf_nxt;
   logic [3:0]       r_bdp, w_bdp_nxt;
   logic [3:0]       r_seen, w_seen_nxt;
   logic [3:0]       r_serr, w_serr_nxt;
   logic [15:0]      r_digits;
   logic [3:0]       r_dpm;
   logic             r_fv, r_ferr, r_an_err;

   assign w_cur     = {an, seg, dp};
   assign w_chg     = (w_cur != r_prev);
   assign w_onehot  = (an == 4'b1110) || (an == 4'b1101) ||
                      (an == 4'b1011) || (an == 4'b0111);
   assign w_an_bad  = !w_onehot && (an != 4'b1111);
   assign w_cnt_nxt = w_chg ? 4'd0 : ((r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1);

   always_comb begin
      w_code = 4'hF;
      case (seg)
         7'b1000000: w_code = 4'h0;
         7'b1111001: w_code = 4'h1;
         7'b0100100: w_code = 4'h2;
         7'b0110000: w_code = 4'h3;
         7'b0011001: w_code = 4'h4;
         7'b0010010: w_code = 4'h5;
         7'b0000010: w_code = 4'h6;
         7'b1111000: w_code = 4'h7;
         7'b0000000: w_code = 4'h8;
         7'b0010000: w_code = 4'h9;
         7'b1111111: w_code = 4'hE;
         default:    w_code = 4'hF;
      endcase
   end
   assign w_code_err = (w_code == 4'hF);

   // Any change of the drive restarts the dwell; HELD blocks a second capture.
   always_comb begin
      w_state_nxt = r_state;
      w_cap       = 1'b0;
      if (w_chg) begin
         w_state_nxt = w_onehot ? SETTLE : IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_onehot) w_state_nxt = SETTLE;
            SETTLE:  if (w_cnt_nxt >= 4'(SETTLE_CYCLES)) begin
                        w_state_nxt = HELD;
                        w_cap       = 1'b1;
                     end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Error is tracked per slot so a re-captured slot fully replaces its value.
   always_comb begin
      w_buf_nxt  = r_buf;
      w_bdp_nxt  = r_bdp;
      w_seen_nxt = r_seen;
      w_serr_nxt = r_serr;
      if (w_cap) begin
         for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
               w_buf_nxt[i]  = w_code;
               w_bdp_nxt[i]  = ~dp;
               w_seen_nxt[i] = 1'b1;
               w_serr_nxt[i] = w_code_err;
            end
         end
      end
   end
   assign w_done = w_cap && (w_seen_nxt == 4'b1111);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev   <= '1;
         r_cnt    <= '0;
         r_buf    <= '0;
         r_bdp    <= '0;
         r_seen   <= '0;
         r_serr   <= '0;
         r_digits <= '0;
         r_dpm    <= '0;
         r_fv     <= 1'b0;
         r_ferr   <= 1'b0;
         r_an_err <= 1'b0;
      end else begin
         r_prev   <= w_cur;
         r_cnt    <= w_cnt_nxt;
         r_buf    <= w_buf_nxt;
         r_bdp    <= w_bdp_nxt;
         r_an_err <= w_an_bad;
         r_fv     <= w_done;
         if (w_done) begin
            r_seen   <= '0;
            r_serr   <= '0;
            r_digits <= w_buf_nxt;
            r_dpm    <= w_bdp_nxt;
            r_ferr   <= |w_serr_nxt;
         end else begin
            r_seen <= w_seen_nxt;
            r_serr <= w_serr_nxt;
         end
      end
   end

   assign digits      = r_digits;
   assign dp_mask     = r_dpm;
   assign frame_valid = r_fv;
   assign frame_err   = r_ferr;
   assign an_err      = r_an_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans multiplexed digit patterns and
// checks recovered frames, error flags and reset behaviour.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic [15:0] digits;
   logic [3:0]  dp_mask;
   logic        frame_valid, frame_err, an_err;

   int n_cmp = 0;
   int n_bad = 0;
   int fv_cnt = 0;
   int ae_cnt = 0;
   int fv0, ae0;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, SBL = 7'b1111111,
                          SBAD = 7'b1010101;

   seg_scan_decoder #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .seg(seg), .an(an), .dp(dp),
      .digits(digits), .dp_mask(dp_mask), .frame_valid(frame_valid),
      .frame_err(frame_err), .an_err(an_err)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled shortly after each active edge.
   always @(posedge clk) begin
      #2;
      if (frame_valid) fv_cnt++;
      if (an_err)      ae_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller is always at a negedge; inputs change there, away from posedge.
   task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
      an = a; seg = s; dp = d;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                       input logic [6:0] s0, input logic [3:0] dpn);
      hold(4'b0111, s3, dpn[3], 4);
      hold(4'b1011, s2, dpn[2], 4);
      hold(4'b1101, s1, dpn[1], 4);
      hold(4'b1110, s0, dpn[0], 4);
   endtask

   initial begin
      rst = 1'b1; an = 4'b1111; seg = 7'h7F; dp = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_digits", 32'(digits), 32'h0000);
      check("rst_dpmask", 32'(dp_mask), 32'h0);
      check("rst_fv", 32'(frame_valid), 32'h0);
      check("rst_ferr", 32'(frame_err), 32'h0);
      check("rst_anerr", 32'(an_err), 32'h0);
      rst = 1'b0;
      hold(4'b1111, 7'h7F, 1'b1, 2);

      // 12:34 with a cycle-exact latency probe on the final digit
      fv0 = fv_cnt;
      hold(4'b0111, S1, 1'b1, 4);
      hold(4'b1011, S2, 1'b1, 4);
      hold(4'b1101, S3, 1'b1, 4);
      hold(4'b1110, S4, 1'b1, 2);
      check("lat_before", 32'(frame_valid), 32'h0);
      hold(4'b1110, S4, 1'b1, 1);
      check("lat_pulse", 32'(frame_valid), 32'h1);
      hold(4'b1110, S4, 1'b1, 1);
      check("lat_after", 32'(frame_valid), 32'h0);
      check("f1_count", 32'(fv_cnt - fv0), 32'd1);
      check("f1_digits", 32'(digits), 32'h1234);
      check("f1_ferr", 32'(frame_err), 32'h0);
      check("f1_dpmask", 32'(dp_mask), 32'h0);

      // dp on digit1, blank digit2
      fv0 = fv_cnt;
      scan(S1, SBL, S3, S4, 4'b1101);
      check("f2_count", 32'(fv_cnt - fv0), 32'd1);
      check("f2_digits", 32'(digits), 32'h1E34);
      check("f2_dpmask", 32'(dp_mask), 32'b0010);
      check("f2_ferr", 32'(frame_err), 32'h0);

      // undecodable digit0, then a clean frame
      scan(S1, S2, S3, SBAD, 4'b1111);
      check("f3_d0", 32'(digits[3:0]), 32'hF);
      check("f3_ferr", 32'(frame_err), 32'h1);
      scan(S1, S2, S3, S4, 4'b1111);
      check("f4_ferr", 32'(frame_err), 32'h0);
      check("f4_digits", 32'(digits), 32'h1234);

      // one-cycle dwell on digit0 must not capture
      fv0 = fv_cnt;
      hold(4'b0111, S4, 1'b1, 4);
      hold(4'b1011, S3, 1'b1, 4);
      hold(4'b1101, S2, 1'b1, 4);
      hold(4'b1110, S1, 1'b1, 1);
      hold(4'b1111, 7'h7F, 1'b1, 4);
      check("short_nofv", 32'(fv_cnt - fv0), 32'd0);
      check("short_hold", 32'(digits), 32'h1234);
      hold(4'b1110, S1, 1'b1, 4);
      check("short_fv", 32'(fv_cnt - fv0), 32'd1);
      check("short_digits", 32'(digits), 32'h4321);

      // invalid anode pattern mid-frame
      fv0 = fv_cnt; ae0 = ae_cnt;
      hold(4'b0111, S2, 1'b1, 4);
      hold(4'b1011, S1, 1'b1, 4);
      hold(4'b1100, S0, 1'b1, 1);
      check("anerr_pulse", 32'(an_err), 32'h1);
      hold(4'b1101, S4, 1'b1, 4);
      check("anerr_once", 32'(ae_cnt - ae0), 32'd1);
      hold(4'b1110, S3, 1'b1, 4);
      check("anerr_fv", 32'(fv_cnt - fv0), 32'd1);
      check("anerr_digits", 32'(digits), 32'h2143);

      // reset after three captures discards the partial frame
      hold(4'b0111, S1, 1'b1, 4);
      hold(4'b1011, S2, 1'b1, 4);
      hold(4'b1101, S3, 1'b1, 4);
      rst = 1'b1;
      hold(4'b1111, 7'h7F, 1'b1, 1);
      rst = 1'b0;
      check("mrst_digits", 32'(digits), 32'h0000);
      check("mrst_ferr", 32'(frame_err), 32'h0);
      fv0 = fv_cnt;
      hold(4'b1110, S4, 1'b1, 4);
      hold(4'b1111, 7'h7F, 1'b1, 2);
      check("mrst_nofv", 32'(fv_cnt - fv0), 32'd0);
      check("mrst_hold", 32'(digits), 32'h0000);
      scan(S1, S2, S3, S4, 4'b1111);
      check("mrst_fv", 32'(fv_cnt - fv0), 32'd1);
      check("mrst_digits2", 32'(digits), 32'h1234);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
